// File: rtl/axi_lite_slave_controller.sv
// AXI4-Lite slave front end. Converts AR/R and AW/W/B channel handshakes into
// single-cycle load/store request pulses towards a word-organised memory model,
// then waits for the matching done strobe and returns the R/B response.
// Read and write paths are independent FSMs and may be active at the same time.
//
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   axi_aw*/axi_w*/axi_b*   AXI4-Lite write address, write data, write response
//   axi_ar*/axi_r*          AXI4-Lite read address, read data/response
//   load_*                  memory load request (address relative to BASE_ADDRESS)
//   store_*                 memory store request (address relative to BASE_ADDRESS)
// All outputs are registered.
module axi_lite_slave_controller #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned MEMORY_SIZE  = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] axi_awaddr_i,
  input  logic        axi_awvalid_i,
  output logic        axi_awready_o,
  input  logic [31:0] axi_wdata_i,
  input  logic [3:0]  axi_wstrb_i,
  input  logic        axi_wvalid_i,
  output logic        axi_wready_o,
  output logic [1:0]  axi_bresp_o,
  output logic        axi_bvalid_o,
  input  logic        axi_bready_i,
  input  logic [31:0] axi_araddr_i,
  input  logic        axi_arvalid_i,
  output logic        axi_arready_o,
  output logic [31:0] axi_rdata_o,
  output logic [1:0]  axi_rresp_o,
  output logic        axi_rvalid_o,
  input  logic        axi_rready_i,
  output logic [31:0] load_address_o,
  output logic        load_o,
  input  logic [31:0] load_data_i,
  input  logic        load_done_i,
  output logic [31:0] store_address_o,
  output logic [31:0] store_data_o,
  output logic [3:0]  store_strobe_o,
  output logic        store_o,
  input  logic        store_done_i
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  // 33-bit limit so a window ending at the top of the address space does not wrap.
  localparam logic [32:0] LimitAddr = {1'b0, BASE_ADDRESS} + 33'(MEMORY_SIZE) * 33'd4;

  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE_ADDRESS}) && ({1'b0, addr} < LimitAddr);
  endfunction

  typedef enum logic [1:0] {RIdle, RLoad, RWait, RResp} r_state_e;
  typedef enum logic [1:0] {WIdle, WStore, WWait, WResp} w_state_e;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        load_q;
  logic [31:0] load_address_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state_q      <= RIdle;
      arready_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= '0;
      rresp_q        <= '0;
      load_q         <= 1'b0;
      load_address_q <= '0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (axi_arvalid_i && arready_q) begin
            arready_q <= 1'b0;
            if (in_range(axi_araddr_i)) begin
              load_address_q <= axi_araddr_i - BASE_ADDRESS;
              load_q         <= 1'b1;
              r_state_q      <= RLoad;
            end else begin
              rdata_q   <= '0;
              rresp_q   <= RespSlvErr;
              rvalid_q  <= 1'b1;
              r_state_q <= RResp;
            end
          end else begin
            // Also raises arready on the first edge out of reset.
            arready_q <= 1'b1;
          end
        end
        RLoad: begin
          load_q    <= 1'b0;
          r_state_q <= RWait;
        end
        RWait: begin
          if (load_done_i) begin
            rdata_q   <= load_data_i;
            rresp_q   <= RespOkay;
            rvalid_q  <= 1'b1;
            r_state_q <= RResp;
          end
        end
        RResp: begin
          if (axi_rready_i) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q;
  logic        awready_q;
  logic        wready_q;
  logic        aw_got_q;
  logic        w_got_q;
  logic [31:0] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        store_q;
  logic [31:0] store_address_q;
  logic [31:0] store_data_q;
  logic [3:0]  store_strobe_q;

  logic        aw_hs;
  logic        w_hs;
  logic [31:0] aw_addr_now;
  logic [31:0] w_data_now;
  logic [3:0]  w_strb_now;

  assign aw_hs = axi_awvalid_i && awready_q;
  assign w_hs  = axi_wvalid_i && wready_q;

  // Channel contents as seen this cycle: latched copy if it arrived earlier,
  // otherwise the bus value being handshaken right now.
  assign aw_addr_now = aw_got_q ? awaddr_q : axi_awaddr_i;
  assign w_data_now  = w_got_q  ? wdata_q  : axi_wdata_i;
  assign w_strb_now  = w_got_q  ? wstrb_q  : axi_wstrb_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      w_state_q       <= WIdle;
      awready_q       <= 1'b0;
      wready_q        <= 1'b0;
      aw_got_q        <= 1'b0;
      w_got_q         <= 1'b0;
      awaddr_q        <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      bvalid_q        <= 1'b0;
      bresp_q         <= '0;
      store_q         <= 1'b0;
      store_address_q <= '0;
      store_data_q    <= '0;
      store_strobe_q  <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (aw_hs) begin
            awaddr_q  <= axi_awaddr_i;
            aw_got_q  <= 1'b1;
            awready_q <= 1'b0;
          end else if (!aw_got_q) begin
            awready_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= axi_wdata_i;
            wstrb_q  <= axi_wstrb_i;
            w_got_q  <= 1'b1;
            wready_q <= 1'b0;
          end else if (!w_got_q) begin
            wready_q <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            if (in_range(aw_addr_now)) begin
              store_address_q <= aw_addr_now - BASE_ADDRESS;
              store_data_q    <= w_data_now;
              store_strobe_q  <= w_strb_now;
              store_q         <= 1'b1;
              w_state_q       <= WStore;
            end else begin
              bresp_q   <= RespSlvErr;
              bvalid_q  <= 1'b1;
              w_state_q <= WResp;
            end
          end
        end
        WStore: begin
          store_q   <= 1'b0;
          w_state_q <= WWait;
        end
        WWait: begin
          if (store_done_i) begin
            bresp_q   <= RespOkay;
            bvalid_q  <= 1'b1;
            w_state_q <= WResp;
          end
        end
        WResp: begin
          if (axi_bready_i) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  assign axi_arready_o   = arready_q;
  assign axi_rvalid_o    = rvalid_q;
  assign axi_rdata_o     = rdata_q;
  assign axi_rresp_o     = rresp_q;
  assign load_o          = load_q;
  assign load_address_o  = load_address_q;
  assign axi_awready_o   = awready_q;
  assign axi_wready_o    = wready_q;
  assign axi_bvalid_o    = bvalid_q;
  assign axi_bresp_o     = bresp_q;
  assign store_o         = store_q;
  assign store_address_o = store_address_q;
  assign store_data_o    = store_data_q;
  assign store_strobe_o  = store_strobe_q;

endmodule

// File: tb/tb_axi_lite_slave_controller.sv
// Scoreboard bench for axi_lite_slave_controller: stimulus pushes the expected
// R/B responses and load/store requests into queues; a negedge monitor pops and
// compares whenever the DUT presents one. A small memory model answers requests.
module tb_axi_lite_slave_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] load_address;
  logic        load;
  logic [31:0] load_data;
  logic        load_done;
  logic [31:0] store_address;
  logic [31:0] store_data;
  logic [3:0]  store_strobe;
  logic        store;
  logic        store_done;
  logic        mem_stall = 1'b0;

  always #5 clk = ~clk;

  axi_lite_slave_controller #(
    .BASE_ADDRESS(32'h0000_0000),
    .MEMORY_SIZE (32)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .axi_awaddr_i   (awaddr),
    .axi_awvalid_i  (awvalid),
    .axi_awready_o  (awready),
    .axi_wdata_i    (wdata),
    .axi_wstrb_i    (wstrb),
    .axi_wvalid_i   (wvalid),
    .axi_wready_o   (wready),
    .axi_bresp_o    (bresp),
    .axi_bvalid_o   (bvalid),
    .axi_bready_i   (bready),
    .axi_araddr_i   (araddr),
    .axi_arvalid_i  (arvalid),
    .axi_arready_o  (arready),
    .axi_rdata_o    (rdata),
    .axi_rresp_o    (rresp),
    .axi_rvalid_o   (rvalid),
    .axi_rready_i   (rready),
    .load_address_o (load_address),
    .load_o         (load),
    .load_data_i    (load_data),
    .load_done_i    (load_done),
    .store_address_o(store_address),
    .store_data_o   (store_data),
    .store_strobe_o (store_strobe),
    .store_o        (store),
    .store_done_i   (store_done)
  );

  // Memory model: word i initialised to i, answers one cycle after a request.
  logic [31:0] mem [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
      load_done  <= 1'b0;
      store_done <= 1'b0;
      load_data  <= '0;
    end else begin
      load_done  <= 1'b0;
      store_done <= 1'b0;
      if (load && !mem_stall) begin
        load_done <= 1'b1;
        load_data <= mem[load_address[6:2]];
      end
      if (store) begin
        for (int b = 0; b < 4; b++)
          if (store_strobe[b]) mem[store_address[6:2]][8*b +: 8] <= store_data[8*b +: 8];
        store_done <= 1'b1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] data; logic [1:0] resp;} r_exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} st_exp_t;
  r_exp_t      exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] exp_ld[$];
  st_exp_t     exp_st[$];
  r_exp_t      mon_r;
  st_exp_t     mon_st;
  logic [1:0]  mon_b;
  logic [31:0] mon_ld;

  // Monitor: every presented response / request must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          mon_r = exp_r.pop_front();
          chk("rdata", 64'(rdata), 64'(mon_r.data));
          chk("rresp", 64'(rresp), 64'(mon_r.resp));
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          mon_b = exp_b.pop_front();
          chk("bresp", 64'(bresp), 64'(mon_b));
        end
      end
      if (load) begin
        if (exp_ld.size() == 0) chk("load_unexpected", 64'd1, 64'd0);
        else begin
          mon_ld = exp_ld.pop_front();
          chk("load_address", 64'(load_address), 64'(mon_ld));
        end
      end
      if (store) begin
        if (exp_st.size() == 0) chk("store_unexpected", 64'd1, 64'd0);
        else begin
          mon_st = exp_st.pop_front();
          chk("store_address", 64'(store_address), 64'(mon_st.addr));
          chk("store_data", 64'(store_data), 64'(mon_st.data));
          chk("store_strobe", 64'(store_strobe), 64'(mon_st.strb));
        end
      end
    end
  end

  function automatic logic any_output();
    return |{awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid, load_address,
             load, store_address, store_data, store_strobe, store};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [31:0] a);
    logic hs = 1'b0;
    araddr  = a;
    arvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = arready;
      tick();
    end
    arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_aw(input logic [31:0] a);
    logic hs = 1'b0;
    awaddr  = a;
    awvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = awready;
      tick();
    end
    awvalid = 1'b0;
    if (!hs) chk("aw_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic hs = 1'b0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    for (int n = 0; n < 50 && !hs; n++) begin
      @(negedge clk);
      hs = wready;
      tick();
    end
    wvalid = 1'b0;
    if (!hs) chk("w_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_resp(input logic need_r, input logic need_b);
    logic r_seen = !need_r;
    logic b_seen = !need_b;
    for (int n = 0; n < 50 && !(r_seen && b_seen); n++) begin
      @(negedge clk);
      r_seen = r_seen || (rvalid && rready);
      b_seen = b_seen || (bvalid && bready);
    end
    if (!r_seen) chk("r_timeout", 64'd0, 64'd1);
    if (!b_seen) chk("b_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    exp_r.push_back('{data: d, resp: resp});
    if (resp == 2'b00) exp_ld.push_back(a);
    send_ar(a);
    wait_resp(1'b1, 1'b0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp, input int lead);
    exp_b.push_back(resp);
    if (resp == 2'b00) exp_st.push_back('{addr: a, data: d, strb: s});
    fork
      begin
        repeat (lead) tick();
        send_aw(a);
      end
      send_w(d, s);
    join
    wait_resp(1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end

  initial begin
    // Reset state and ready rise on the first edge after release.
    @(negedge clk);
    chk("reset_outputs", 64'(any_output()), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", 64'({arready, awready, wready}), 64'd0);
    tick();
    @(negedge clk);
    chk("ready_after_edge", 64'({arready, awready, wready}), 64'h7);
    tick();

    // Read latency with a one-cycle memory.
    rready = 1'b1;
    bready = 1'b1;
    exp_r.push_back('{data: 32'h3, resp: 2'b00});
    exp_ld.push_back(32'h0C);
    araddr  = 32'h0C;
    arvalid = 1'b1;
    @(negedge clk);
    chk("lat_T_arready", 64'(arready), 64'd1);
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    chk("lat_T1_load", 64'(load), 64'd1);
    chk("lat_T1_arready", 64'(arready), 64'd0);
    tick();
    @(negedge clk);
    chk("lat_T2_load", 64'(load), 64'd0);
    chk("lat_T2_rvalid", 64'(rvalid), 64'd0);
    tick();
    @(negedge clk);
    chk("lat_T3_rvalid", 64'(rvalid), 64'd1);
    tick();
    @(negedge clk);
    chk("lat_T4_rvalid", 64'(rvalid), 64'd0);
    chk("lat_T4_arready", 64'(arready), 64'd1);
    tick();

    // W two cycles ahead of AW; 0xDEADBEEF with strobe 0101 over 4.
    do_write(32'h10, 32'hDEAD_BEEF, 4'b0101, 2'b00, 2);
    do_read(32'h10, 32'h00AD_00EF, 2'b00);

    // Range boundaries.
    do_read(32'h7C, 32'd31, 2'b00);
    do_read(32'h80, 32'h0, 2'b10);
    do_read(32'hFFFF_FFFC, 32'h0, 2'b10);
    do_write(32'h80, 32'h1111_1111, 4'hF, 2'b10, 0);

    // Backpressure: responses held for 5 cycles with readies low.
    rready = 1'b0;
    bready = 1'b0;
    exp_r.push_back('{data: 32'h2, resp: 2'b00});
    exp_ld.push_back(32'h08);
    exp_b.push_back(2'b00);
    exp_st.push_back('{addr: 32'h14, data: 32'h1234_5678, strb: 4'hF});
    fork
      send_ar(32'h08);
      send_aw(32'h14);
      send_w(32'h1234_5678, 4'hF);
    join
    begin
      logic both = 1'b0;
      for (int n = 0; n < 20 && !both; n++) begin
        @(negedge clk);
        both = rvalid && bvalid;
      end
      chk("bp_responses_present", 64'(both), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valids", 64'({rvalid, bvalid}), 64'h3);
      chk("bp_rdata", 64'(rdata), 64'h2);
      chk("bp_bresp", 64'(bresp), 64'd0);
      chk("bp_readies", 64'({arready, awready, wready}), 64'd0);
    end
    tick();
    rready = 1'b1;
    bready = 1'b1;
    wait_resp(1'b1, 1'b1);

    // Concurrent AR and AW+W in one cycle; zero write strobe.
    exp_r.push_back('{data: 32'h1234_5678, resp: 2'b00});
    exp_ld.push_back(32'h14);
    exp_b.push_back(2'b00);
    exp_st.push_back('{addr: 32'h18, data: 32'hA5A5_A5A5, strb: 4'h0});
    fork
      send_ar(32'h14);
      send_aw(32'h18);
      send_w(32'hA5A5_A5A5, 4'h0);
    join
    @(negedge clk);
    chk("conc_load_store", 64'({load, store}), 64'h3);
    wait_resp(1'b1, 1'b1);
    do_read(32'h18, 32'h6, 2'b00);

    // Reset while the read waits on memory and the write is in its store cycle.
    mem_stall = 1'b1;
    exp_ld.push_back(32'h04);
    send_ar(32'h04);
    tick();
    tick();
    fork
      send_aw(32'h1C);
      send_w(32'hCAFE_F00D, 4'hF);
    join
    chk("rst_store_pulse_live", 64'(store), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_immediate", 64'(any_output()), 64'd0);
    mem_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs_held", 64'(any_output()), 64'd0);
    end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    do_read(32'h04, 32'h1, 2'b00);
    repeat (3) tick();

    chk("queue_r_empty", 64'(exp_r.size()), 64'd0);
    chk("queue_b_empty", 64'(exp_b.size()), 64'd0);
    chk("queue_load_empty", 64'(exp_ld.size()), 64'd0);
    chk("queue_store_empty", 64'(exp_st.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
